// File: rtl/spi_pkg.sv
// Shared SPI definitions: frame-engine state type, SPI mode constants and
// the ADS1256 opcodes used by the routine controller.
package spi_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_DRDY,
    ST_CS_SETUP,
    ST_SCLK_HIGH,
    ST_SCLK_LOW,
    ST_GAP,
    ST_CS_HOLD,
    ST_DONE
  } spi_frame_state_t;

  // SPI mode 1: clock idles low, data launched on the rising edge and
  // captured on the falling edge.
  localparam logic SPI_CPOL = 1'b0;
  localparam logic SPI_CPHA = 1'b1;

  // ADS1256 command opcodes.
  localparam logic [7:0] ADS_RDATA   = 8'h01;
  localparam logic [7:0] ADS_RDATAC  = 8'h03;
  localparam logic [7:0] ADS_SDATAC  = 8'h0F;
  localparam logic [7:0] ADS_SELFCAL = 8'hF0;

endpackage

// File: rtl/spi_sclk_timer.sv
// Down-counter shared by every timed state of the frame engine. A load sets
// the phase length; expire_o is high during the last cycle of that phase.
module spi_sclk_timer #(
  parameter int CNT_W = 8
) (
  input  logic             clock_i,
  input  logic             reset_L_i,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  output logic             expire_o
);

  logic [CNT_W-1:0] r_cnt;

  // Load a new phase length or count the current one down to zero.
  always_ff @(posedge clock_i or negedge reset_L_i) begin
    if (!reset_L_i) begin
      r_cnt <= '0;
    end else if (load_i) begin
      r_cnt <= load_val_i;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign expire_o = (r_cnt == CNT_W'(1));

endmodule

// File: rtl/spi_frame_master.sv
// SPI mode-1 frame master for the ADS1256: 1..MAX_BYTES bytes per frame,
// programmable SCLK half period, optional DRDY_L gate and an optional idle
// gap after a chosen byte.
// Optional feature macro: SPI_FRAME_DRDY_SYNC_EN (2-flop DRDY_L synchronizer).
// Pin outputs are registered from the current state, so each pin follows the
// state register by one clock; abort overrides this and idles the pins on the
// very edge that accepts it.
module spi_frame_master
  import spi_pkg::*;
#(
  parameter int MAX_BYTES = 4,
  parameter int DIV_W     = 8,
  parameter int GAP_W     = 8,
  parameter int BCNT_W    = $clog2(MAX_BYTES) + 1
) (
  input  logic                   clock_i,
  input  logic                   reset_L_i,
  input  logic                   start_i,
  input  logic                   abort_i,
  input  logic [BCNT_W-1:0]      n_bytes_i,
  input  logic [8*MAX_BYTES-1:0] tx_data_i,
  input  logic [DIV_W-1:0]       half_period_i,
  input  logic [BCNT_W-1:0]      gap_after_i,
  input  logic [GAP_W-1:0]       gap_cycles_i,
  input  logic                   wait_drdy_i,
  output logic                   busy_o,
  output logic                   done_o,
  output logic [8*MAX_BYTES-1:0] rx_data_o,
  input  logic                   MISO_i,
  input  logic                   DRDY_L_i,
  output logic                   MOSI_o,
  output logic                   SCLK_o,
  output logic                   CS_L_o
);

  localparam int CNT_W = (DIV_W > GAP_W) ? DIV_W : GAP_W;
  localparam int FW    = 8 * MAX_BYTES;

  spi_frame_state_t r_state, w_state_next;

  logic [BCNT_W-1:0] r_n, r_gap_after, r_byte;
  logic [2:0]        r_bit;
  logic [DIV_W-1:0]  r_h;
  logic [GAP_W-1:0]  r_g;
  logic [FW-1:0]     r_tx, r_rx;
  logic              r_sclk, r_cs_l, r_mosi, r_busy, r_done;

  logic              w_load, w_expire, w_accept, w_abort, w_drdy_l, w_bit_end;
  logic [CNT_W-1:0]  w_load_val;
  logic [BCNT_W-1:0] w_n_in, w_byte_inc;
  logic [DIV_W-1:0]  w_h_in;

  assign w_n_in     = (n_bytes_i > BCNT_W'(MAX_BYTES)) ? BCNT_W'(MAX_BYTES) : n_bytes_i;
  assign w_h_in     = (half_period_i == '0) ? DIV_W'(1) : half_period_i;
  assign w_byte_inc = r_byte + 1'b1;
  assign w_accept   = (r_state == ST_IDLE) && start_i;
  assign w_abort    = (r_state != ST_IDLE) && abort_i;
  assign w_bit_end  = (r_state == ST_SCLK_LOW) && w_expire && !w_abort;

`ifdef SPI_FRAME_DRDY_SYNC_EN
  logic [1:0] r_drdy_sync;

  // Two-flop synchronizer for the asynchronous DRDY_L pin (idles high).
  always_ff @(posedge clock_i or negedge reset_L_i) begin
    if (!reset_L_i) begin
      r_drdy_sync <= 2'b11;
    end else begin
      r_drdy_sync <= {r_drdy_sync[0], DRDY_L_i};
    end
  end

  assign w_drdy_l = r_drdy_sync[1];
`else
  assign w_drdy_l = DRDY_L_i;
`endif

  spi_sclk_timer #(
    .CNT_W(CNT_W)
  ) u_timer (
    .clock_i   (clock_i),
    .reset_L_i (reset_L_i),
    .load_i    (w_load),
    .load_val_i(w_load_val),
    .expire_o  (w_expire)
  );

  // State register.
  always_ff @(posedge clock_i or negedge reset_L_i) begin
    if (!reset_L_i) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic and timer reloads; every timed state loads its length
  // on the edge that enters it.
  always_comb begin
    w_state_next = r_state;
    w_load       = 1'b0;
    w_load_val   = CNT_W'(r_h);
    case (r_state)
      ST_IDLE: begin
        if (start_i) begin
          if (w_n_in == '0) begin
            w_state_next = ST_DONE;
          end else if (wait_drdy_i) begin
            w_state_next = ST_WAIT_DRDY;
          end else begin
            w_state_next = ST_CS_SETUP;
            w_load       = 1'b1;
            w_load_val   = CNT_W'(w_h_in);
          end
        end
      end
      ST_WAIT_DRDY: begin
        if (!w_drdy_l) begin
          w_state_next = ST_CS_SETUP;
          w_load       = 1'b1;
        end
      end
      ST_CS_SETUP, ST_GAP: begin
        if (w_expire) begin
          w_state_next = ST_SCLK_HIGH;
          w_load       = 1'b1;
        end
      end
      ST_SCLK_HIGH: begin
        if (w_expire) begin
          w_state_next = ST_SCLK_LOW;
          w_load       = 1'b1;
        end
      end
      ST_SCLK_LOW: begin
        if (w_expire) begin
          w_load = 1'b1;
          if (r_bit == 3'd7 && w_byte_inc == r_n) begin
            w_state_next = ST_CS_HOLD;
          end else if (r_bit == 3'd7 && w_byte_inc == r_gap_after && r_g != '0) begin
            w_state_next = ST_GAP;
            w_load_val   = CNT_W'(r_g);
          end else begin
            w_state_next = ST_SCLK_HIGH;
          end
        end
      end
      ST_CS_HOLD: begin
        if (w_expire) begin
          w_state_next = ST_DONE;
        end
      end
      ST_DONE: begin
        w_state_next = ST_IDLE;
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
    if (w_abort) begin
      w_state_next = ST_IDLE;
      w_load       = 1'b0;
    end
  end

  // Pin and status registers; SCLK edges are detected from r_sclk so MOSI
  // launches on the rising edge and MISO is captured on the falling edge.
  always_ff @(posedge clock_i or negedge reset_L_i) begin
    if (!reset_L_i) begin
      r_cs_l <= 1'b1;
      r_sclk <= SPI_CPOL;
      r_mosi <= 1'b0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
      r_rx   <= '0;
    end else if (w_abort) begin
      r_cs_l <= 1'b1;
      r_sclk <= SPI_CPOL;
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_cs_l <= !(r_state inside {ST_CS_SETUP, ST_SCLK_HIGH, ST_SCLK_LOW, ST_GAP, ST_CS_HOLD});
      r_sclk <= SPI_CPOL ^ (r_state == ST_SCLK_HIGH);
      r_done <= (r_state == ST_DONE);
      if (w_accept) begin
        r_busy <= 1'b1;
      end else if (r_state == ST_DONE) begin
        r_busy <= 1'b0;
      end
      if (r_state == ST_SCLK_HIGH && !r_sclk) begin
        r_mosi <= r_tx[FW-1];
      end
      if (w_accept) begin
        r_rx <= '0;
      end else if (r_state == ST_SCLK_LOW && r_sclk) begin
        r_rx <= {r_rx[FW-2:0], MISO_i};
      end
    end
  end

  // Frame parameters captured at start, plus the bit/byte position counters.
  always_ff @(posedge clock_i or negedge reset_L_i) begin
    if (!reset_L_i) begin
      r_n         <= '0;
      r_gap_after <= '0;
      r_byte      <= '0;
      r_bit       <= '0;
      r_h         <= DIV_W'(1);
      r_g         <= '0;
      r_tx        <= '0;
    end else if (w_accept) begin
      r_n         <= w_n_in;
      r_gap_after <= gap_after_i;
      r_byte      <= '0;
      r_bit       <= '0;
      r_h         <= w_h_in;
      r_g         <= gap_cycles_i;
      r_tx        <= tx_data_i;
    end else if (w_bit_end) begin
      r_bit <= r_bit + 3'd1;
      r_tx  <= {r_tx[FW-2:0], 1'b0};
      if (r_bit == 3'd7) begin
        r_byte <= w_byte_inc;
      end
    end
  end

  assign busy_o    = r_busy;
  assign done_o    = r_done;
  assign rx_data_o = r_rx;
  assign MOSI_o    = r_mosi;
  assign SCLK_o    = r_sclk;
  assign CS_L_o    = r_cs_l;

endmodule

// File: tb/tb_spi_frame_master.sv
// Self-checking bench for spi_frame_master (MAX_BYTES=4, DIV_W=8, GAP_W=8).
// A behavioural SPI slave shifts a 32-bit word out MSB first on every SCLK
// rise and records MOSI on every SCLK fall.
module tb_spi_frame_master;

  logic        clock_i = 1'b0;
  logic        reset_L_i = 1'b1;
  logic        start_i = 1'b0;
  logic        abort_i = 1'b0;
  logic [2:0]  n_bytes_i = '0;
  logic [31:0] tx_data_i = '0;
  logic [7:0]  half_period_i = '0;
  logic [2:0]  gap_after_i = '0;
  logic [7:0]  gap_cycles_i = '0;
  logic        wait_drdy_i = 1'b0;
  logic        MISO_i = 1'b0;
  logic        DRDY_L_i = 1'b1;
  logic        busy_o, done_o, MOSI_o, SCLK_o, CS_L_o;
  logic [31:0] rx_data_o;

  spi_frame_master #(.MAX_BYTES(4), .DIV_W(8), .GAP_W(8)) dut (
    .clock_i(clock_i), .reset_L_i(reset_L_i), .start_i(start_i), .abort_i(abort_i),
    .n_bytes_i(n_bytes_i), .tx_data_i(tx_data_i), .half_period_i(half_period_i),
    .gap_after_i(gap_after_i), .gap_cycles_i(gap_cycles_i), .wait_drdy_i(wait_drdy_i),
    .busy_o(busy_o), .done_o(done_o), .rx_data_o(rx_data_o),
    .MISO_i(MISO_i), .DRDY_L_i(DRDY_L_i), .MOSI_o(MOSI_o), .SCLK_o(SCLK_o), .CS_L_o(CS_L_o)
  );

  always #5 clock_i = ~clock_i;

  int checks = 0;
  int errors = 0;

  logic [31:0] slave_sh = '0;
  logic [31:0] mosi_sh = '0;
  int          rises = 0;
  int          cs_bad = 0;

  // Slave: present next bit on each SCLK rise, watch that CS is asserted.
  always @(posedge SCLK_o) begin
    rises  = rises + 1;
    if (CS_L_o) cs_bad = cs_bad + 1;
    MISO_i   = slave_sh[31];
    slave_sh = {slave_sh[30:0], 1'b0};
  end

  // Slave: record master data on each SCLK fall.
  always @(negedge SCLK_o) begin
    mosi_sh = {mosi_sh[30:0], MOSI_o};
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reference model written from the frame rules, not the implementation.
  task automatic model(input logic [2:0] n, input logic [7:0] h, input logic [2:0] ga,
                       input logic [7:0] g, input logic [31:0] tx, input logic [31:0] slave,
                       output int done_c, output logic [31:0] rx, output int nrise,
                       output logic [31:0] mosi, output int run);
    int  ne, he;
    bit  gap;
    ne  = (n > 3'd4) ? 4 : int'(n);
    he  = (h == 8'd0) ? 1 : int'(h);
    gap = (ga != 3'd0) && (int'(ga) < ne) && (g != 8'd0);
    done_c = (ne == 0) ? 1 : 1 + 2 * he + 16 * he * ne + (gap ? int'(g) : 0);
    rx = '0;
    mosi = '0;
    for (int i = 0; i < ne; i++) begin
      rx   = {rx[23:0], slave[31-8*i -: 8]};
      mosi = {mosi[23:0], tx[31-8*i -: 8]};
    end
    nrise = 8 * ne;
    run   = (ne == 0) ? 0 : (gap ? he + int'(g) : he);
  endtask

  task automatic run_frame(input string tag, input logic [2:0] n, input logic [7:0] h,
                           input logic [2:0] ga, input logic [7:0] g, input logic [31:0] tx,
                           input logic [31:0] slave, input bit abort_with_start, input int inject_at,
                           input int exp_done, input logic [31:0] exp_rx, input int exp_rises);
    int          m_done, m_rises, m_run, done_k, run, maxrun, cs_low;
    logic [31:0] m_rx, m_mosi;
    model(n, h, ga, g, tx, slave, m_done, m_rx, m_rises, m_mosi, m_run);
    @(negedge clock_i);
    n_bytes_i = n; half_period_i = h; gap_after_i = ga; gap_cycles_i = g;
    tx_data_i = tx; wait_drdy_i = 1'b0;
    slave_sh = slave; rises = 0; cs_bad = 0; mosi_sh = '0;
    start_i = 1'b1; abort_i = abort_with_start;
    @(negedge clock_i);
    start_i = 1'b0; abort_i = 1'b0;
    check({tag, "_busy_k0"}, 64'(busy_o), 64'd1);
    done_k = -1; run = 0; maxrun = 0; cs_low = 0;
    for (int k = 1; k <= 4000; k++) begin
      if (k == inject_at) begin
        start_i = 1'b1; n_bytes_i = 3'd3;
      end else begin
        start_i = 1'b0;
      end
      @(negedge clock_i);
      if (!CS_L_o) cs_low++;
      if (SCLK_o) begin
        if (run > maxrun) maxrun = run;
        run = 0;
      end else if (!CS_L_o) begin
        run++;
      end else begin
        run = 0;
      end
      if (done_o) begin
        done_k = k;
        break;
      end
    end
    start_i = 1'b0;
    $display("frame %s n=%0d h=%0d ga=%0d g=%0d done_k=%0d rx=%08h rises=%0d", tag, n, h, ga, g,
             done_k, rx_data_o, rises);
    check({tag, "_done_cycle"}, 64'(done_k), 64'(exp_done));
    check({tag, "_busy_at_done"}, 64'(busy_o), 64'd0);
    check({tag, "_rx"}, 64'(rx_data_o), 64'(exp_rx));
    check({tag, "_sclk_rises"}, 64'(rises), 64'(exp_rises));
    check({tag, "_mosi"}, 64'(mosi_sh), 64'(m_mosi));
    check({tag, "_sclk_low_run"}, 64'(maxrun), 64'(m_run));
    check({tag, "_cs_at_sclk"}, 64'(cs_bad), 64'd0);
    if (n == 3'd0) check({tag, "_cs_never_low"}, 64'(cs_low), 64'd0);
    @(negedge clock_i);
    check({tag, "_post_done"}, 64'({done_o, busy_o, CS_L_o}), 64'(3'b001));
    repeat (3) @(negedge clock_i);
  endtask

  typedef struct {
    string       tag;
    logic [2:0]  n;
    logic [7:0]  h;
    logic [2:0]  ga;
    logic [7:0]  g;
    logic [31:0] tx;
    logic [31:0] slave;
    bit          abort_with_start;
    int          exp_done;
    logic [31:0] exp_rx;
    int          exp_rises;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int          seen, lat, bad, m_done, m_rises, m_run;
    logic [31:0] m_rx, m_mosi;
    logic [2:0]  rn, rga;
    logic [7:0]  rh, rg;
    logic [31:0] rtx, rsl;

    vecs[0] = '{"rdata",      3'd4, 8'd2, 3'd1, 8'd50, 32'h0100_0000, 32'h0012_3456, 1'b0, 183, 32'h0012_3456, 32};
    vecs[1] = '{"n0",         3'd0, 8'd3, 3'd0, 8'd0,  32'hDEAD_BEEF, 32'hFFFF_FFFF, 1'b0, 1,   32'h0,         0};
    vecs[2] = '{"h0_n1",      3'd1, 8'd0, 3'd0, 8'd0,  32'hA500_0000, 32'h3C00_0000, 1'b0, 19,  32'h0000_003C, 8};
    vecs[3] = '{"clamp",      3'd7, 8'd1, 3'd0, 8'd0,  32'h1234_5678, 32'h89AB_CDEF, 1'b0, 67,  32'h89AB_CDEF, 32};
    vecs[4] = '{"gap_ge_n",   3'd2, 8'd3, 3'd2, 8'd9,  32'hF00F_0000, 32'h5AA5_0000, 1'b0, 103, 32'h0000_5AA5, 16};
    vecs[5] = '{"start_abrt", 3'd3, 8'd1, 3'd2, 8'd5,  32'hC3A5_5A00, 32'h1122_3300, 1'b1, 56,  32'h0011_2233, 24};

    // Reset values, checked while reset is held and before any clock edge.
    #1 reset_L_i = 1'b0;
    #2 check("reset_values", 64'({SCLK_o, CS_L_o, MOSI_o, busy_o, done_o, rx_data_o}),
             64'({1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0}));
    #9 reset_L_i = 1'b1;
    repeat (2) @(negedge clock_i);

    foreach (vecs[i]) begin
      run_frame(vecs[i].tag, vecs[i].n, vecs[i].h, vecs[i].ga, vecs[i].g, vecs[i].tx, vecs[i].slave,
                vecs[i].abort_with_start, -1, vecs[i].exp_done, vecs[i].exp_rx, vecs[i].exp_rises);
    end

    // start_i pulsed mid-frame must be ignored.
    run_frame("busy_start", 3'd1, 8'd1, 3'd0, 8'd0, 32'h8100_0000, 32'h6900_0000, 1'b0, 5,
              19, 32'h0000_0069, 8);

    // DRDY gate: CS stays high while DRDY_L is high, then falls after it drops.
    @(negedge clock_i);
    n_bytes_i = 3'd1; half_period_i = 8'd1; gap_after_i = 3'd0; gap_cycles_i = 8'd0;
    tx_data_i = 32'h5500_0000; wait_drdy_i = 1'b1; DRDY_L_i = 1'b1;
    slave_sh = 32'hE700_0000; start_i = 1'b1;
    @(negedge clock_i);
    start_i = 1'b0;
    bad = 0;
    repeat (40) begin
      @(negedge clock_i);
      if (!CS_L_o || !busy_o) bad++;
    end
    check("drdy_gate_hold", 64'(bad), 64'd0);
    DRDY_L_i = 1'b0;
    lat = -1;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clock_i);
      if (!CS_L_o) begin
        lat = k;
        break;
      end
    end
`ifdef SPI_FRAME_DRDY_SYNC_EN
    check("drdy_cs_latency", 64'(lat), 64'd4);
`else
    check("drdy_cs_latency", 64'(lat), 64'd2);
`endif
    seen = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clock_i);
      if (done_o) begin
        seen = 1;
        break;
      end
    end
    $display("frame drdy done=%0d rx=%08h", seen, rx_data_o);
    check("drdy_done", 64'(seen), 64'd1);
    check("drdy_rx", 64'(rx_data_o), 64'h0000_00E7);
    DRDY_L_i = 1'b1;
    repeat (3) @(negedge clock_i);

    // Abort while waiting for DRDY_L.
    start_i = 1'b1;
    @(negedge clock_i);
    start_i = 1'b0;
    repeat (5) @(negedge clock_i);
    abort_i = 1'b1;
    @(negedge clock_i);
    abort_i = 1'b0;
    check("abort_wait_pins", 64'({CS_L_o, SCLK_o, busy_o}), 64'(3'b100));
    seen = 0;
    repeat (20) begin
      @(negedge clock_i);
      if (done_o) seen++;
    end
    $display("frame abort_wait done_pulses=%0d", seen);
    check("abort_wait_no_done", 64'(seen), 64'd0);
    wait_drdy_i = 1'b0;

    // Abort mid-byte: two bits have been captured when the abort lands.
    n_bytes_i = 3'd2; half_period_i = 8'd2; tx_data_i = 32'hFFFF_0000;
    slave_sh = 32'hC300_0000; start_i = 1'b1;
    @(negedge clock_i);
    start_i = 1'b0;
    repeat (10) @(negedge clock_i);
    abort_i = 1'b1;
    @(negedge clock_i);
    abort_i = 1'b0;
    check("abort_byte_pins", 64'({CS_L_o, SCLK_o, busy_o}), 64'(3'b100));
    check("abort_byte_rx_partial", 64'(rx_data_o), 64'h3);
    seen = 0;
    repeat (20) begin
      @(negedge clock_i);
      if (done_o) seen++;
    end
    $display("frame abort_byte done_pulses=%0d rx=%08h", seen, rx_data_o);
    check("abort_byte_no_done", 64'(seen), 64'd0);

    // Asynchronous reset mid-frame, then a normal frame.
    n_bytes_i = 3'd2; half_period_i = 8'd1; tx_data_i = 32'hFFFF_0000;
    slave_sh = 32'hFFFF_0000; start_i = 1'b1;
    @(negedge clock_i);
    start_i = 1'b0;
    repeat (8) @(negedge clock_i);
    #2 reset_L_i = 1'b0;
    #1 check("reset_midframe", 64'({SCLK_o, CS_L_o, MOSI_o, busy_o, done_o, rx_data_o}),
             64'({1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0}));
    @(negedge clock_i);
    reset_L_i = 1'b1;
    @(negedge clock_i);
    model(3'd2, 8'd2, 3'd1, 8'd4, 32'hA1B2_0000, 32'h7E81_0000, m_done, m_rx, m_rises, m_mosi, m_run);
    run_frame("after_reset", 3'd2, 8'd2, 3'd1, 8'd4, 32'hA1B2_0000, 32'h7E81_0000, 1'b0, -1,
              m_done, m_rx, m_rises);

    // Randomised frames against the reference model.
    for (int r = 0; r < 8; r++) begin
      rn  = 3'($urandom_range(0, 7));
      rh  = 8'($urandom_range(0, 4));
      rga = 3'($urandom_range(0, 5));
      rg  = 8'($urandom_range(0, 20));
      rtx = $urandom;
      rsl = $urandom;
      model(rn, rh, rga, rg, rtx, rsl, m_done, m_rx, m_rises, m_mosi, m_run);
      run_frame($sformatf("rand%0d", r), rn, rh, rga, rg, rtx, rsl, 1'b0, -1, m_done, m_rx, m_rises);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_frame_master.md
# spi_frame_master

Parametrised SPI master frame engine; successor to the fixed 24-bit command engine inside `spi_top`. It shifts a variable-length frame of 1..MAX_BYTES bytes in SPI mode 1 (CPOL=0, CPHA=1, as the ADS1256 requires). The frame has a programmable SCLK rate, an optional DRDY_L gate before chip-select, and an optional idle gap after a chosen byte (ADS1256 t6 command-to-data delay). It sits between the routine controller and the ADS1256 pins.

## Interface
- MAX_BYTES, 4: largest frame in bytes; BCNT_W = $clog2(MAX_BYTES)+1.
- DIV_W, 8: width of the SCLK half-period field.
- GAP_W, 8: width of the inter-byte gap field.
- clock_i  in  1  system clock; one clock.
- reset_L_i  in  1  asynchronous, active-low reset.
- start_i  in  1  frame request; sampled only when idle.
- abort_i  in  1  cancel the current frame.
- n_bytes_i  in  BCNT_W  frame length; values above MAX_BYTES clamp to MAX_BYTES.
- tx_data_i  in  8*MAX_BYTES  left-aligned; byte 0 = [8*MAX_BYTES-1 -: 8].
- half_period_i  in  DIV_W  SCLK half period in clocks (H); 0 is treated as 1.
- gap_after_i  in  BCNT_W  gap inserted after this many bytes; 0 = no gap.
- gap_cycles_i  in  GAP_W  gap length G in clocks.
- wait_drdy_i  in  1  wait for DRDY_L low before asserting CS.
- busy_o  out  1  frame in progress.
- done_o  out  1  one-cycle completion pulse.
- rx_data_o  out  8*MAX_BYTES  received bytes, right-aligned; first byte most significant.
- MISO_i, DRDY_L_i  in  1  ADS1256 pins.
- MOSI_o, SCLK_o, CS_L_o  out  1  ADS1256 pins.

## Operation
- Reset values: SCLK_o=0, CS_L_o=1, MOSI_o=0, busy_o=0, done_o=0, rx_data_o=0, state IDLE.
- States: IDLE, WAIT_DRDY, CS_SETUP, SCLK_HIGH, SCLK_LOW, GAP, CS_HOLD, DONE.
- IDLE, start_i=1:
  - Capture all inputs, clear rx_data_o, set busy_o.
  - Go to WAIT_DRDY if wait_drdy_i=1, else CS_SETUP.
- start_i while busy: ignored.
- WAIT_DRDY: CS_L high; leave when DRDY_L is seen low.
- CS_SETUP: CS_L low, SCLK low, H cycles.
- Each bit is one SCLK_HIGH phase (H cycles) followed by one SCLK_LOW phase (H cycles).
  - MOSI_o changes on the edge that raises SCLK, MSB first.
  - MISO_i is registered on the edge that drops SCLK and shifted into rx_data_o bit 0.
- GAP: after the last bit of byte gap_after_i, when bytes remain and G>0, SCLK is held low for G cycles.
- No gap when gap_after_i is 0 or gap_after_i ≥ n_bytes.
- After the last byte: CS_HOLD (CS_L low, H cycles), then DONE.
  - DONE: CS_L high, done_o=1, busy_o=0, then IDLE.
- rx_data_o is held until the next accepted start.
- n_bytes_i=0: DONE at cycle 1; CS_L never asserts.
- abort_i in any non-IDLE state: next edge goes to IDLE with CS_L=1, SCLK=0. No done_o. rx_data_o keeps its partial contents.
- abort_i and start_i together in IDLE: start wins.
- reset_L_i low mid-frame: outputs take their reset values immediately, without waiting for a clock edge.

## Timing
- Cycle 0 is the edge that samples start_i.
- With no DRDY wait, CS_L falls at cycle 1.
- done_o is high in cycle 1 + H + 16·H·N + G + H.
- DRDY wait: CS_L falls 1 cycle after DRDY_L is seen low.
- SCLK duty is 50%; period is 2H clocks.

## Configuration
- SPI_FRAME_DRDY_SYNC_EN defined: DRDY_L_i passes through a 2-flop synchronizer. This adds 2 cycles to the DRDY-to-CS_L latency.
- Undefined: DRDY_L_i is used directly and must be synchronous to clock_i.
- MISO_i is never synchronized; H ≥ 1 already gives a full clock of setup.

## Structure
- Shared `spi_pkg` holds:
  - the `spi_frame_state_t` enum;
  - constants SPI_CPOL=0 and SPI_CPHA=1;
  - ADS1256 opcode localparams (RDATA 8'h01, RDATAC 8'h03, SDATAC 8'h0F, SELFCAL 8'hF0).
- One sub-module, `spi_sclk_timer`, is natural:
  - loads H, G or a setup count;
  - counts down and pulses `expire` on the last cycle;
  - the FSM uses it for every timed state.

## Test plan
- RDATA: MAX_BYTES=4, H=2, N=4, tx=32'h0100_0000, gap_after=1, G=50; model returns 00,12,34,56.
  - rx_data_o=32'h0012_3456.
  - SCLK low for 50 cycles between bytes 1 and 2.
  - done_o at cycle 183.
  - Exactly 32 SCLK rising edges.
- DRDY gate: wait_drdy=1, DRDY_L high for 40 cycles.
  - CS_L stays high and busy_o=1.
  - CS_L falls 1 cycle after DRDY_L goes low (3 with the macro defined).
- Abort: abort_i during WAIT_DRDY and again mid-byte.
  - Next cycle: CS_L=1, SCLK=0, busy_o=0.
  - No done_o.
- Reset: reset_L_i low mid-frame → all outputs at reset values before the next clock edge; a later start runs a normal frame.
- Edge inputs:
  - n_bytes=0 → done_o at cycle 1, CS_L never low.
  - start_i while busy → ignored.
  - H=0, N=1 → done_o at cycle 19 (as for H=1).
- Clamp: n_bytes=7 with MAX_BYTES=4 → exactly 32 SCLK pulses.
